// File: rtl/predicate_pkg.sv
// +--------------------------------------------------------------------+
// | predicate_pkg                                                      |
// | Shared sizes and FSM encoding for the predicate access controller. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package predicate_pkg;

  localparam int NUM_LANES = 16;
  localparam int NUM_REGS  = 64;
  localparam int NUM_WARPS = 16;
  localparam int AW        = $clog2(NUM_REGS);
  localparam int WW        = $clog2(NUM_WARPS);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pr_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/predicate_access_ctrl_if.sv
// +--------------------------------------------------------------------+
// | predicate_access_ctrl_if                                           |
// | Client-side read/write/clear handshake of the predicate controller.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface predicate_access_ctrl_if;
  import predicate_pkg::*;

  logic                 rd_req;
  logic [WW-1:0]        rd_warp;
  logic [AW-1:0]        rd_addr_0;
  logic [AW-1:0]        rd_addr_1;
  logic [NUM_LANES-1:0] rd_en_0;
  logic [NUM_LANES-1:0] rd_en_1;
  logic                 rd_gnt;
  logic                 rd_rsp_valid;
  logic [NUM_LANES-1:0] rd_rsp_data_0;
  logic [NUM_LANES-1:0] rd_rsp_data_1;

  logic                 wr_req;
  logic [WW-1:0]        wr_warp;
  logic [AW-1:0]        wr_addr;
  logic [NUM_LANES-1:0] wr_mask;
  logic [NUM_LANES-1:0] wr_data;
  logic                 wr_gnt;

  logic                 clr_req;
  logic [WW-1:0]        clr_warp;
  logic                 clr_busy;
  logic                 clr_done;

  modport master (
    output rd_req, rd_warp, rd_addr_0, rd_addr_1, rd_en_0, rd_en_1,
    input  rd_gnt, rd_rsp_valid, rd_rsp_data_0, rd_rsp_data_1,
    output wr_req, wr_warp, wr_addr, wr_mask, wr_data,
    input  wr_gnt,
    output clr_req, clr_warp,
    input  clr_busy, clr_done
  );

  modport slave (
    input  rd_req, rd_warp, rd_addr_0, rd_addr_1, rd_en_0, rd_en_1,
    output rd_gnt, rd_rsp_valid, rd_rsp_data_0, rd_rsp_data_1,
    input  wr_req, wr_warp, wr_addr, wr_mask, wr_data,
    output wr_gnt,
    input  clr_req, clr_warp,
    output clr_busy, clr_done
  );

endinterface

`default_nettype wire

// File: rtl/predicate_clear_seq.sv
// +--------------------------------------------------------------------+
// | predicate_clear_seq                                                |
// | Walks every register address of one warp, one per cycle.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module predicate_clear_seq
  import predicate_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start_i,
  input  wire logic [WW-1:0] warp_i,
  output logic               busy_o,
  output logic [AW-1:0]      addr_o,
  output logic [WW-1:0]      warp_o,
  output logic               done_o
);

  pr_ctrl_state_t state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  warp_q, warp_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      warp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warp_q  <= warp_d;
      done_q  <= done_d;
    end
  end

  // A start pulse arriving while already clearing is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    warp_d  = warp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          warp_d  = warp_i;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == CLEAR);
  assign addr_o = cnt_q;
  assign warp_o = warp_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/predicate_access_ctrl.sv
// +--------------------------------------------------------------------+
// | predicate_access_ctrl                                              |
// | Arbitrates read/write/clear access to the predicate register block.|
// | Optional macro: PRED_WR_BYPASS_EN (same-address write-to-read fwd). |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module predicate_access_ctrl
  import predicate_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  predicate_access_ctrl_if.slave    bus,
  output logic [WW-1:0]             pr_warp_selector,
  output logic [NUM_LANES-1:0]      pr_read_en_0,
  output logic [NUM_LANES-1:0]      pr_read_en_1,
  output logic [AW-1:0]             pr_raddr_0,
  output logic [AW-1:0]             pr_raddr_1,
  output logic [NUM_LANES-1:0]      pr_write_en,
  output logic [AW-1:0]             pr_waddr,
  output logic [NUM_LANES-1:0]      pr_wdata,
  input  wire logic [NUM_LANES-1:0] pr_rdata_0,
  input  wire logic [NUM_LANES-1:0] pr_rdata_1
);

  logic                 clr_busy;
  logic                 clr_done;
  logic [AW-1:0]        clr_addr;
  logic [WW-1:0]        clr_warp;

  logic                 conflict;
  logic                 rd_gnt;
  logic                 wr_gnt;
  logic                 wr_prio_q, wr_prio_d;
  logic [WW-1:0]        sel_q;
  logic                 rsp_valid_q;
  logic [NUM_LANES-1:0] rsp_data_0_q, rsp_data_0_d;
  logic [NUM_LANES-1:0] rsp_data_1_q, rsp_data_1_d;
  logic [NUM_LANES-1:0] byp_0;
  logic [NUM_LANES-1:0] byp_1;

  predicate_clear_seq u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bus.clr_req),
    .warp_i  (bus.clr_warp),
    .busy_o  (clr_busy),
    .addr_o  (clr_addr),
    .warp_o  (clr_warp),
    .done_o  (clr_done)
  );

  // wr_prio_q is set after a read wins a differing-warp conflict, so the
  // next such conflict goes to the write side; reset favours the read.
  assign conflict = bus.rd_req && bus.wr_req && (bus.rd_warp != bus.wr_warp);
  assign rd_gnt   = !clr_busy && bus.rd_req && (!conflict || !wr_prio_q);
  assign wr_gnt   = !clr_busy && bus.wr_req && (!conflict ||  wr_prio_q);

  always_comb begin
    wr_prio_d = wr_prio_q;
    if (!clr_busy && conflict) begin
      wr_prio_d = !wr_prio_q;
    end
  end

  always_comb begin
    pr_warp_selector = sel_q;
    pr_read_en_0     = '0;
    pr_read_en_1     = '0;
    pr_write_en      = '0;
    pr_waddr         = bus.wr_addr;
    pr_wdata         = bus.wr_data;
    if (clr_busy) begin
      pr_warp_selector = clr_warp;
      pr_write_en      = '1;
      pr_waddr         = clr_addr;
      pr_wdata         = '0;
    end else begin
      if (rd_gnt) begin
        pr_warp_selector = bus.rd_warp;
        pr_read_en_0     = bus.rd_en_0;
        pr_read_en_1     = bus.rd_en_1;
      end else if (wr_gnt) begin
        pr_warp_selector = bus.wr_warp;
      end
      if (wr_gnt) begin
        pr_write_en = bus.wr_mask;
      end
    end
  end

  assign pr_raddr_0 = bus.rd_addr_0;
  assign pr_raddr_1 = bus.rd_addr_1;

  // Both grants together imply the same warp, so only the address is compared.
`ifdef PRED_WR_BYPASS_EN
  assign byp_0 = (wr_gnt && (bus.rd_addr_0 == bus.wr_addr)) ? bus.wr_mask : '0;
  assign byp_1 = (wr_gnt && (bus.rd_addr_1 == bus.wr_addr)) ? bus.wr_mask : '0;
`else
  assign byp_0 = '0;
  assign byp_1 = '0;
`endif

  always_comb begin
    rsp_data_0_d = rsp_data_0_q;
    rsp_data_1_d = rsp_data_1_q;
    if (rd_gnt) begin
      rsp_data_0_d = ((pr_rdata_0 & ~byp_0) | (bus.wr_data & byp_0)) & bus.rd_en_0;
      rsp_data_1_d = ((pr_rdata_1 & ~byp_1) | (bus.wr_data & byp_1)) & bus.rd_en_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prio_q    <= 1'b0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_0_q <= '0;
      rsp_data_1_q <= '0;
    end else begin
      wr_prio_q    <= wr_prio_d;
      sel_q        <= pr_warp_selector;
      rsp_valid_q  <= rd_gnt;
      rsp_data_0_q <= rsp_data_0_d;
      rsp_data_1_q <= rsp_data_1_d;
    end
  end

  assign bus.rd_gnt        = rd_gnt;
  assign bus.wr_gnt        = wr_gnt;
  assign bus.rd_rsp_valid  = rsp_valid_q;
  assign bus.rd_rsp_data_0 = rsp_data_0_q;
  assign bus.rd_rsp_data_1 = rsp_data_1_q;
  assign bus.clr_busy      = clr_busy;
  assign bus.clr_done      = clr_done;

endmodule

`default_nettype wire

// File: doc/predicate_access_ctrl.md
# predicate_access_ctrl

Controller sitting in front of `predicate_register_block` that shares its two read ports, one write port and its single global `warp_selector` among three clients: the issue-stage read requester, the writeback write requester and an internal warp-clear sequencer. Read and write can share a cycle only when they target the same warp, so differing-warp conflicts are arbitrated round-robin. Read data is registered and returned one cycle after grant.

## Interface
- `NUM_LANES`, 16: lanes per warp (one predicate bit per lane).
- `NUM_REGS`, 64: predicate registers per warp; `AW = $clog2(NUM_REGS)`.
- `NUM_WARPS`, 16: warps; `WW = $clog2(NUM_WARPS)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  read request; held stable until `rd_gnt`.
- `rd_warp`  in  WW  warp to read.
- `rd_addr_0`, `rd_addr_1`  in  AW  register addresses for ports 0/1.
- `rd_en_0`, `rd_en_1`  in  NUM_LANES  per-lane read enables for ports 0/1.
- `rd_gnt`  out  1  read accepted this cycle.
- `rd_rsp_valid`  out  1  registered response valid.
- `rd_rsp_data_0`, `rd_rsp_data_1`  out  NUM_LANES  registered read data; lanes with enable 0 return 0.
- `wr_req`  in  1  write request; held until `wr_gnt`.
- `wr_warp`  in  WW; `wr_addr`  in  AW; `wr_mask`  in  NUM_LANES; `wr_data`  in  NUM_LANES.
- `wr_gnt`  out  1  write accepted (lands at this cycle's rising edge).
- `clr_req`  in  1  one-cycle pulse: zero all registers of `clr_warp`.
- `clr_warp`  in  WW  warp to clear.
- `clr_busy`  out  1  clear sequence in progress.
- `clr_done`  out  1  one-cycle pulse after final clear write.
- `pr_warp_selector`  out  WW; `pr_read_en_0/1`  out  NUM_LANES; `pr_raddr_0/1`  out  AW; `pr_write_en`  out  NUM_LANES; `pr_waddr`  out  AW; `pr_wdata`  out  NUM_LANES (bit i drives `wdata_i`).
- `pr_rdata_0`, `pr_rdata_1`  in  NUM_LANES  combinational read data from the register block.

## Operation
- FSM states: IDLE, CLEAR.
- IDLE arbitration (combinational grants):
  - only one of rd/wr requesting: granted.
  - both, `rd_warp == wr_warp`: both granted.
  - both, warps differ: winner is the side not flagged by `last_wr`; `last_wr` <= (write won). Reset value 0 (read wins first conflict).
- `pr_warp_selector` = granted warp; with no grant it holds its last value. `pr_read_en_*`/`pr_write_en` are 0 for ungranted sides; `pr_write_en = wr_mask` on write grant.
- `clr_req` in IDLE: the same cycle arbitrates normally; next cycle enters CLEAR. `clr_req` during CLEAR is ignored.
- CLEAR: counter 0..NUM_REGS-1, one write per cycle, `pr_write_en` all ones, `pr_wdata` 0, selector = latched `clr_warp`. `rd_gnt` and `wr_gnt` are 0. After address NUM_REGS-1, return to IDLE; `clr_done` pulses in the first IDLE cycle.
- Read response: on `rd_gnt`, capture `pr_rdata_* & rd_en_*` and set `rd_rsp_valid` for one cycle.
- Same-cycle read and write to the same warp/address: the read returns the pre-write value (see Configuration).

## Timing
- Reset: state IDLE, counter 0, `last_wr` 0, `pr_warp_selector` 0, all `pr_*` enables 0, `rd_rsp_valid`/`clr_busy`/`clr_done` 0, `rd_rsp_data_*` 0.
- Grants are combinational from requests. Read latency is 1 cycle grant-to-response. A write is visible to a read granted in the next cycle.
- Clear occupancy: 64 cycles busy (`clr_busy` high), then `clr_done` pulses in cycle 65 after acceptance.
- Reset mid-clear: abort immediately to IDLE with no `clr_done`.

## Configuration
- `PRED_WR_BYPASS_EN` defined: on a same-cycle same-warp same-address read/write, lanes with `wr_mask=1` return `wr_data` in the response.
- Not defined: the response returns the old register value.

## Structure
- Package `predicate_pkg`: NUM_LANES/NUM_REGS/NUM_WARPS constants, AW/WW widths, `pr_ctrl_state_t` enum {IDLE, CLEAR}.
- Sub-module `predicate_clear_seq`: address counter, busy and done generation. The arbiter and response registers live in the top.

## Test plan
- Write warp 3, addr 10, mask FFFF, data A5A5; read next cycle -> `rd_rsp_data_0` = A5A5 one cycle after grant.
- Read warp 2 and write warp 5 held together for 4 cycles -> grants alternate rd, wr, rd, wr; selector 2, 5, 2, 5.
- Read and write both on warp 7, addr 0 -> both granted in one cycle; response old value, or `wr_data` lanes with `PRED_WR_BYPASS_EN`.
- Fill warp 4 with FFFF, then `clr_req` -> 64 busy cycles with grants blocked; `clr_done` pulse; all 64 reads return 0000; warp 5 data unchanged.
- `rd_en_0` = 00FF on all-ones register -> response 00FF.
- `rst_n` low at clear address 30 -> IDLE, `clr_busy` 0, no `clr_done`, grants resume.
